// File: rtl/dds_ctrl_gen2.sv
// DDS controller: phase accumulator + phase offset drive a 4-wave ROM; key steps retune freq/phase.
// Latency: acc -> rom_addr 1 clk -> dac_data ROM_LAT+1 clk; free-running stream, no backpressure.
module dds_ctrl_gen2 #(
  parameter int ACC_W       = 32,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 10,
  parameter int FRE_STEP    = 8580,
  parameter int FRE_CNT_MAX = 99,
  parameter int PHA_STEP    = 256,
  parameter int PHA_CNT_MAX = 7,
  parameter int SWEEP_DIV   = 50000,
  parameter int ROM_LAT     = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              fre_adjust,
  input  logic              pha_adjust,
  input  logic              sweep_en,
  input  logic [1:0]        wave_sel,
  output logic [ADDR_W+1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              start_flag,
  output logic              param_chg
);

  localparam int FI_W = (FRE_CNT_MAX > 0) ? $clog2(FRE_CNT_MAX + 1) : 1;
  localparam int PI_W = (PHA_CNT_MAX > 0) ? $clog2(PHA_CNT_MAX + 1) : 1;
  localparam int SW_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

  localparam logic [ACC_W-1:0]  FRE_STEP_W = ACC_W'(FRE_STEP);
  localparam logic [ADDR_W-1:0] PHA_STEP_W = ADDR_W'(PHA_STEP);
  localparam logic [FI_W-1:0]   FRE_MAX_W  = FI_W'(FRE_CNT_MAX);
  localparam logic [PI_W-1:0]   PHA_MAX_W  = PI_W'(PHA_CNT_MAX);
  localparam logic [SW_W-1:0]   SWEEP_LAST = SW_W'(SWEEP_DIV - 1);

  logic [1:0]        fre_sync, pha_sync;
  logic              fre_prev, pha_prev;
  logic              fre_rise, pha_rise;
  logic [SW_W-1:0]   sweep_cnt;
  logic              sweep_wrap;
  logic              fre_step, pha_step;
  logic [FI_W-1:0]   f_idx;
  logic [ACC_W-1:0]  f_word;
  logic [PI_W-1:0]   p_idx;
  logic [ADDR_W-1:0] p_off;
  logic [ACC_W-1:0]  acc;
  logic [ROM_LAT:0]  valid_sr;

  // Rise pulses are registered, so a step lands on the 4th clock after the key rises.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fre_sync <= '0;
      pha_sync <= '0;
      fre_prev <= 1'b0;
      pha_prev <= 1'b0;
      fre_rise <= 1'b0;
      pha_rise <= 1'b0;
    end else begin
      fre_sync <= {fre_sync[0], fre_adjust};
      pha_sync <= {pha_sync[0], pha_adjust};
      fre_prev <= fre_sync[1];
      pha_prev <= pha_sync[1];
      fre_rise <= fre_sync[1] & ~fre_prev;
      pha_rise <= pha_sync[1] & ~pha_prev;
    end
  end

  assign sweep_wrap = sweep_en && (sweep_cnt == SWEEP_LAST);
  assign fre_step   = sweep_en ? sweep_wrap : fre_rise;
  assign pha_step   = pha_rise;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sweep_cnt <= '0;
    end else if (!sweep_en || sweep_wrap) begin
      sweep_cnt <= '0;
    end else begin
      sweep_cnt <= sweep_cnt + SW_W'(1);
    end
  end

  // f_word tracks (f_idx+1)*FRE_STEP by accumulation; p_off wraps naturally in ADDR_W bits.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      f_idx     <= '0;
      f_word    <= FRE_STEP_W;
      p_idx     <= '0;
      p_off     <= '0;
      param_chg <= 1'b0;
    end else begin
      if (fre_step) begin
        if (f_idx == FRE_MAX_W) begin
          f_idx  <= '0;
          f_word <= FRE_STEP_W;
        end else begin
          f_idx  <= f_idx + FI_W'(1);
          f_word <= f_word + FRE_STEP_W;
        end
      end
      if (pha_step) begin
        if (p_idx == PHA_MAX_W) begin
          p_idx <= '0;
          p_off <= '0;
        end else begin
          p_idx <= p_idx + PI_W'(1);
          p_off <= p_off + PHA_STEP_W;
        end
      end
      param_chg <= fre_step | pha_step;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc      <= '0;
      rom_addr <= '0;
      dac_data <= '0;
    end else begin
      acc      <= acc + f_word;
      rom_addr <= {~wave_sel, acc[ACC_W-1 -: ADDR_W] + p_off};
      dac_data <= rom_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_sr   <= '0;
      dac_valid  <= 1'b0;
      start_flag <= 1'b0;
    end else begin
      valid_sr   <= {valid_sr[ROM_LAT-1:0], 1'b1};
      dac_valid  <= valid_sr[ROM_LAT];
      start_flag <= dac_valid;
    end
  end

endmodule

// File: tb/tb_dds_ctrl_gen2.sv
// Bench for dds_ctrl_gen2: directed vector table, directed corner sequences, randomized run vs reference model.
module tb_dds_ctrl_gen2;
  localparam int ACC_W       = 32;
  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 10;
  localparam int FRE_STEP    = 1048576;
  localparam int FRE_CNT_MAX = 99;
  localparam int PHA_STEP    = 256;
  localparam int PHA_CNT_MAX = 7;
  localparam int SWEEP_DIV   = 4;
  localparam int ROM_LAT     = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b1;
  logic              fre_adjust = 1'b0;
  logic              pha_adjust = 1'b0;
  logic              sweep_en = 1'b0;
  logic [1:0]        wave_sel = 2'b11;
  logic [ADDR_W+1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              start_flag;
  logic              param_chg;

  always #5 sys_clk = ~sys_clk;

  dds_ctrl_gen2 #(
    .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRE_STEP(FRE_STEP),
    .FRE_CNT_MAX(FRE_CNT_MAX), .PHA_STEP(PHA_STEP), .PHA_CNT_MAX(PHA_CNT_MAX),
    .SWEEP_DIV(SWEEP_DIV), .ROM_LAT(ROM_LAT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fre_adjust(fre_adjust),
    .pha_adjust(pha_adjust), .sweep_en(sweep_en), .wave_sel(wave_sel),
    .rom_addr(rom_addr), .rom_q(rom_q), .dac_data(dac_data),
    .dac_valid(dac_valid), .start_flag(start_flag), .param_chg(param_chg)
  );

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W+1:0] a);
    logic [31:0] t;
    t = (32'(a) * 32'd37) ^ (32'(a) >> 5);
    return t[DATA_W-1:0];
  endfunction

  // External ROM with ROM_LAT clocks of read latency
  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge sys_clk) begin
    rom_pipe[0] <= rom_fn(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  int checks = 0;
  int errors = 0;
  int chg_seen = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: indices, total phase and a history of sampled key levels.
  longint unsigned   m_acc;
  int                m_fidx, m_pidx, m_sc, cyc;
  bit                fq[$], pq[$];
  logic [ADDR_W+1:0] ahist[$];
  logic [ADDR_W+1:0] e_addr;
  bit                e_chg, e_valid, e_start;
  logic [DATA_W-1:0] e_dac;

  task automatic model_reset();
    m_acc = 0; m_fidx = 0; m_pidx = 0; m_sc = 0; cyc = 0;
    fq.delete(); pq.delete();
    repeat (4) begin fq.push_back(1'b0); pq.push_back(1'b0); end
    ahist.delete(); ahist.push_back('0);
    e_addr = '0; e_chg = 0; e_valid = 0; e_start = 0; e_dac = '0;
  endtask

  task automatic model_step();
    bit frise, prise, fstep;
    logic [ADDR_W-1:0] lo;
    cyc++;
    fq.push_back(fre_adjust);
    pq.push_back(pha_adjust);
    frise = fq[$-3] && !fq[$-4];
    prise = pq[$-3] && !pq[$-4];
    void'(fq.pop_front());
    void'(pq.pop_front());
    m_sc  = sweep_en ? m_sc + 1 : 0;
    fstep = sweep_en ? (m_sc % SWEEP_DIV == 0) : frise;
    lo = ADDR_W'((m_acc >> (ACC_W - ADDR_W)) + longint'(m_pidx * PHA_STEP));
    e_addr = {~wave_sel, lo};
    m_acc = (m_acc + longint'(m_fidx + 1) * longint'(FRE_STEP)) % (64'd1 << ACC_W);
    if (fstep) m_fidx = (m_fidx + 1) % (FRE_CNT_MAX + 1);
    if (prise) m_pidx = (m_pidx + 1) % (PHA_CNT_MAX + 1);
    e_chg = fstep || prise;
    ahist.push_back(e_addr);
    e_valid = (cyc >= ROM_LAT + 2);
    e_start = (cyc >= ROM_LAT + 3);
    if (e_valid) e_dac = rom_fn(ahist[cyc - 1 - ROM_LAT]);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    chk("rom_addr", longint'(rom_addr), longint'(e_addr));
    chk("dac_valid", longint'(dac_valid), longint'(e_valid));
    chk("start_flag", longint'(start_flag), longint'(e_start));
    chk("param_chg", longint'(param_chg), longint'(e_chg));
    if (e_valid) chk("dac_data", longint'(dac_data), longint'(e_dac));
    if (param_chg) chg_seen++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rom_addr"}, longint'(rom_addr), 0);
    chk({tag, "_dac_data"}, longint'(dac_data), 0);
    chk({tag, "_dac_valid"}, longint'(dac_valid), 0);
    chk({tag, "_start_flag"}, longint'(start_flag), 0);
    chk({tag, "_param_chg"}, longint'(param_chg), 0);
  endtask

  // Called at a falling edge: assert reset between edges, check, release on a later falling edge.
  task automatic areset();
    #2 sys_rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic press(input int hi, input int lo);
    fre_adjust = 1'b1;
    repeat (hi) tick();
    fre_adjust = 1'b0;
    repeat (lo) tick();
  endtask

  typedef struct {
    logic [1:0] ws;
    bit         sw, pha, fre;
    int         addr;
    bit         v, s, c;
  } vec_t;
  vec_t tbl[11];

  initial begin
    logic [ADDR_W+1:0] a0;
    tbl[0]  = '{2'd3, 1'b0, 1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'd3, 1'b0, 1'b1, 1'b0, 1,     1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'd3, 1'b0, 1'b1, 1'b0, 2,     1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'd3, 1'b0, 1'b1, 1'b0, 3,     1'b1, 1'b0, 1'b0};
    tbl[4]  = '{2'd3, 1'b0, 1'b1, 1'b0, 4,     1'b1, 1'b1, 1'b1};
    tbl[5]  = '{2'd3, 1'b0, 1'b1, 1'b1, 261,   1'b1, 1'b1, 1'b0};
    tbl[6]  = '{2'd0, 1'b0, 1'b1, 1'b1, 12550, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{2'd0, 1'b0, 1'b1, 1'b1, 12551, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{2'd0, 1'b0, 1'b1, 1'b1, 12552, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{2'd0, 1'b0, 1'b0, 1'b0, 12553, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{2'd0, 1'b0, 1'b0, 1'b0, 12555, 1'b1, 1'b1, 1'b0};

    #1 sys_rst_n = 1'b0;
    #1 check_zero("reset");
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Ramp start, valid/start timing, key latency, wave select
    for (int i = 0; i < 11; i++) begin
      wave_sel   = tbl[i].ws;
      sweep_en   = tbl[i].sw;
      pha_adjust = tbl[i].pha;
      fre_adjust = tbl[i].fre;
      tick();
      chk($sformatf("tbl%0d_addr", i), longint'(rom_addr), longint'(tbl[i].addr));
      chk($sformatf("tbl%0d_valid", i), longint'(dac_valid), longint'(tbl[i].v));
      chk($sformatf("tbl%0d_start", i), longint'(start_flag), longint'(tbl[i].s));
      chk($sformatf("tbl%0d_chg", i), longint'(param_chg), longint'(tbl[i].c));
    end

    // Mid-run reset restores base frequency and zero phase
    areset();
    tick();
    tick();
    chk("post_rst_addr", longint'(rom_addr[ADDR_W-1:0]), 1);
    a0 = rom_addr;
    tick();
    chk("post_rst_step", longint'((rom_addr - a0) & 14'hFFF), 1);

    // Frequency wrap: a wide press then 98 short ones reach the top index, one more wraps
    chg_seen = 0;
    press(10, 3);
    for (int i = 0; i < 98; i++) press(2, 2);
    repeat (3) tick();
    a0 = rom_addr;
    tick();
    chk("fre_top_step", longint'((rom_addr - a0) & 14'hFFF), 100);
    press(2, 5);
    a0 = rom_addr;
    tick();
    chk("fre_wrap_step", longint'((rom_addr - a0) & 14'hFFF), 1);
    chk("fre_pulses", chg_seen, 100);

    // Sweep ignores key edges and steps every SWEEP_DIV clocks
    chg_seen = 0;
    sweep_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      fre_adjust = (i < 34) ? i[0] : 1'b0;
      tick();
    end
    sweep_en = 1'b0;
    chk("sweep_pulses", chg_seen, 10);

    // Phase step coinciding with a sweep step yields a single pulse
    chg_seen = 0;
    sweep_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pha_adjust = (i >= 4);
      tick();
    end
    chk("sweep_pha_pulses", chg_seen, 2);
    sweep_en = 1'b0;
    pha_adjust = 1'b0;
    repeat (4) tick();

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5, 0) == 0) fre_adjust = ~fre_adjust;
      if ($urandom_range(5, 0) == 0) pha_adjust = ~pha_adjust;
      if ($urandom_range(199, 0) == 0) sweep_en = ~sweep_en;
      if ($urandom_range(99, 0) == 0) wave_sel = 2'($urandom);
      tick();
      if ($urandom_range(999, 0) == 0) areset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
